// File: rtl/ir_protocol_pkg.sv
// Shared IR command-link protocol definition: unit counts, payload width and FSM state encoding.
// Imported by both ir_transmitter and ir_receiver so the two ends cannot drift apart.
package ir_protocol_pkg;

    localparam int START_UNITS  = 4;
    localparam int ONE_UNITS    = 2;
    localparam int ZERO_UNITS   = 1;
    localparam int SPACE_UNITS  = 1;
    localparam int NBITS        = 12;
    localparam int REPEAT_COUNT = 3;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_START_MARK  = 4'd1,
        ST_START_SPACE = 4'd2,
        ST_BIT_MARK    = 4'd3,
        ST_BIT_SPACE   = 4'd4,
        ST_GAP         = 4'd5
    } ir_state_e;

    function automatic logic is_mark(input ir_state_e s);
        return (s == ST_START_MARK) || (s == ST_BIT_MARK);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// 40 kHz carrier for the IR LED, phase-restarted at the first cycle of every mark.
// The output flop already includes the envelope gating, so it can drive the pin directly.
module ir_carrier_gen #(
    parameter int CARRIER_HALF = 312
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic carrier
);

    localparam int CW = $clog2(CARRIER_HALF + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          out_q, out_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        out_d = enable & phase_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            out_q   <= out_d;
        end
    end

    assign carrier = out_q;

endmodule

// File: rtl/ir_transmitter.sv
// Serializes a 12-bit move command into a pulse-width-coded IR frame on a 40 kHz carrier.
// Define IR_TX_REPEAT_EN to send each command three times separated by GAP_UNITS idle units.
module ir_transmitter
    import ir_protocol_pkg::*;
#(
    parameter int UNIT_CYCLES  = 15000,
    parameter int CARRIER_HALF = 312,
    parameter int GAP_UNITS    = 75
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             envelope,
    output logic             ir_out,
    output logic [3:0]       state
);

    localparam int UW = $clog2(UNIT_CYCLES + 1);
    localparam int NW = 7;
    localparam int IW = $clog2(NBITS);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);

    ir_state_e        state_q, state_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic [UW-1:0]    unit_cnt_q, unit_cnt_d;
    logic [NW-1:0]    unit_num_q, unit_num_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             envelope_q, envelope_d;
    logic [NW-1:0]    dur_units;
    logic             unit_last;
    logic             carrier_restart;
`ifdef IR_TX_REPEAT_EN
    logic [1:0]       rep_q, rep_d;
    logic [NBITS-1:0] word_q, word_d;
`endif

    always_comb begin
        case (state_q)
            ST_START_MARK:                 dur_units = NW'(START_UNITS);
            ST_BIT_MARK:                   dur_units = shift_q[0] ? NW'(ONE_UNITS) : NW'(ZERO_UNITS);
            ST_START_SPACE, ST_BIT_SPACE:  dur_units = NW'(SPACE_UNITS);
            ST_GAP:                        dur_units = NW'(GAP_UNITS);
            default:                       dur_units = NW'(1);
        endcase
    end

    assign unit_last = (unit_cnt_q == UNIT_LAST) && (unit_num_q == dur_units - NW'(1));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        unit_cnt_d = unit_cnt_q;
        unit_num_d = unit_num_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef IR_TX_REPEAT_EN
        rep_d      = rep_q;
        word_d     = word_q;
`endif
        if (state_q != ST_IDLE) begin
            if (unit_cnt_q == UNIT_LAST) begin
                unit_cnt_d = '0;
                unit_num_d = unit_last ? '0 : unit_num_q + NW'(1);
            end else begin
                unit_cnt_d = unit_cnt_q + UW'(1);
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_START_MARK;
                    shift_d    = data;
                    bit_idx_d  = '0;
                    unit_cnt_d = '0;
                    unit_num_d = '0;
                    busy_d     = 1'b1;
`ifdef IR_TX_REPEAT_EN
                    word_d     = data;
                    rep_d      = '0;
`endif
                end
            end
            ST_START_MARK:  if (unit_last) state_d = ST_START_SPACE;
            ST_START_SPACE: if (unit_last) state_d = ST_BIT_MARK;
            ST_BIT_MARK:    if (unit_last) state_d = ST_BIT_SPACE;
            ST_BIT_SPACE: begin
                if (unit_last) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + IW'(1);
                    if (bit_idx_q == IW'(NBITS - 1)) begin
`ifdef IR_TX_REPEAT_EN
                        if (rep_q == 2'(REPEAT_COUNT - 1)) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            rep_d   = rep_q + 2'd1;
                        end
`else
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = ST_BIT_MARK;
                    end
                end
            end
            ST_GAP: begin
                if (unit_last) begin
`ifdef IR_TX_REPEAT_EN
                    state_d   = ST_START_MARK;
                    shift_d   = word_q;
                    bit_idx_d = '0;
`else
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        envelope_d = is_mark(state_d);
    end

    // Carrier phase restarts exactly when the envelope is about to rise.
    assign carrier_restart = envelope_d & ~envelope_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            unit_cnt_q <= '0;
            unit_num_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            envelope_q <= 1'b0;
`ifdef IR_TX_REPEAT_EN
            rep_q      <= '0;
            word_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            unit_cnt_q <= unit_cnt_d;
            unit_num_q <= unit_num_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            envelope_q <= envelope_d;
`ifdef IR_TX_REPEAT_EN
            rep_q      <= rep_d;
            word_q     <= word_d;
`endif
        end
    end

    ir_carrier_gen #(
        .CARRIER_HALF (CARRIER_HALF)
    ) u_carrier (
        .clock   (clock),
        .reset   (reset),
        .restart (carrier_restart),
        .enable  (envelope_d),
        .carrier (ir_out)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign envelope = envelope_q;
    assign state    = state_q;

endmodule

// File: doc/ir_transmitter.md
Name: ir_transmitter

Overview:
Base-station side of the IR command link. Serializes a 12-bit move command into a pulse-width-coded IR frame on a 40 kHz carrier, matching the framing the rover's ir_receiver decodes. It sits between the base-station main FSM, which supplies the command and a start strobe, and the IR LED output pin. It runs in the 25 MHz system clock domain.

Parameters:
UNIT_CYCLES, 15000, clock cycles per protocol unit (600 us at 25 MHz)
CARRIER_HALF, 312, clock cycles per carrier half-period (about 40.06 kHz)
NBITS, 12, payload width
GAP_UNITS, 75, idle units between repeated frames (used only with IR_TX_REPEAT_EN)

Ports:
clock  input  1  system clock, 25 MHz
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to send; sampled only while busy=0
data  input  12  command word, latched on an accepted start
busy  output  1  high from the cycle after accept until the frame completes
done  output  1  one-cycle pulse when the final space ends
envelope  output  1  unmodulated mark indicator (1 = LED on-period)
ir_out  output  1  envelope AND carrier; drives the LED
state  output  4  FSM state encoding, for the hex debug display

Behaviour:
- Interface decision: one clock (`clock`); reset (`reset`) is synchronous and active-high.
- All outputs are registered. Reset value is 0 for busy, done, envelope, ir_out and state (0 = IDLE). Reset overrides everything, including an in-flight frame.
- Frame structure, in units:
  - START_MARK: 4 units.
  - SPACE: 1 unit.
  - Then NBITS times, LSB first: BIT_MARK (2 units for a 1, 1 unit for a 0), followed by SPACE (1 unit).
- Frame length: 5 + 24 units for all zeros; 5 + 36 units for all ones.
- FSM states: IDLE(0), START_MARK(1), START_SPACE(2), BIT_MARK(3), BIT_SPACE(4), GAP(5).
- Accepting a request:
  - start=1 in IDLE at edge N: data goes to a shift register, the bit index clears, and the unit counter clears.
  - At N+1: busy=1, envelope=1, state=START_MARK.
  - start while busy=1 is ignored; data changes while busy=1 are ignored.
- Timing:
  - The unit counter counts 0..UNIT_CYCLES-1.
  - A duration of k units lasts exactly k*UNIT_CYCLES cycles.
  - The next state is entered on the cycle after the terminal count.
- Bit sequencing:
  - BIT_MARK duration uses shift[0].
  - On leaving BIT_SPACE: shift right and increment the bit index.
  - After the space for index NBITS-1: go to IDLE, with done=1 and busy=0 in that same cycle.
- done is high for exactly one cycle. A start in that same cycle is accepted, since busy=0. Back-to-back frames are therefore legal.
- Carrier:
  - A counter toggles a carrier flop every CARRIER_HALF cycles.
  - The counter and flop restart at the first cycle of every mark, with carrier=1.
  - ir_out therefore rises together with envelope.
  - ir_out is 0 whenever envelope=0.
- Reset asserted mid-frame: at the next edge all outputs are 0 and the FSM is in IDLE. No done pulse is produced.

Optional Feature:
IR_TX_REPEAT_EN.
- Defined: after the final BIT_SPACE, enter GAP for GAP_UNITS units with envelope=0, then resend the latched word. The frame is sent 3 times total. busy stays 1 throughout. done pulses only after the third frame.
- Undefined: single frame; GAP is unreachable; GAP_UNITS is unused.

Decomposition:
- Shared package ir_protocol_pkg holds:
  - START_UNITS=4, ONE_UNITS=2, ZERO_UNITS=1, SPACE_UNITS=1, NBITS=12, REPEAT_COUNT=3.
  - The state encoding constants.
- ir_receiver imports the same package, so both ends share one protocol definition.
- Natural sub-module: ir_carrier_gen (restart input, enable input, CARRIER_HALF parameter, carrier output).

Test Plan:
All scenarios use UNIT_CYCLES=10 and CARRIER_HALF=2.
1. reset=1 for 3 cycles with start=1 -> busy, envelope and ir_out stay 0; no done pulse.
2. start with data=12'h000 -> envelope high 40 cycles, low 10 cycles, then 12×(high 10, low 10); busy for 290 cycles; one done pulse.
3. start with data=12'hA5C -> mark lengths after the start mark are 10,10,20,20,20,10,20,10,10,20,10,20 (LSB first); a receiver model decodes 12'hA5C.
4. During a mark -> ir_out pattern is 1,1,0,0,... starting on the first envelope cycle; ir_out is 0 throughout every space.
5. Second start issued mid-frame with a different word -> ignored, and the frame carries the original word. A start issued in the done cycle -> accepted; the next frame begins 1 cycle later.
6. reset pulsed at cycle 100 of a frame -> next cycle all outputs are 0 and state=IDLE; no done pulse. A subsequent start sends a clean full frame.
